alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single registered ALU between two requesters: port 0 is the execute stage and port 1 is the address/increment unit. The block arbitrates round-robin, latches the winner's operation and drives the ALU enable, mode and operand inputs for exactly one cycle. It then captures the ALU result and flags and returns them to the winning requester with a one-cycle valid pulse. It sits directly in front of the ALU and owns all of the ALU's inputs.

Parameters:
N, 8, datapath width; must match the ALU's N.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 operation request
mode0  in  3  requester 0 ALU mode (ALU_* encodings)
a0  in  N  requester 0 operand A
b0  in  N  requester 0 operand B
req1  in  1  requester 1 operation request
mode1  in  3  requester 1 ALU mode
a1  in  N  requester 1 operand A
b1  in  N  requester 1 operand B
gnt  out  2  one-hot grant, bit i = requester i accepted
rsp_valid  out  2  one-hot result-valid pulse, bit i = result for requester i
rsp_data  out  N  result value
rsp_zero  out  1  result-is-zero flag
rsp_carry  out  1  carry/borrow flag
busy  out  1  high whenever state is not IDLE
alu_enable  out  1  to ALU enable
alu_mode  out  3  to ALU mode
alu_a  out  N  to ALU in_a
alu_b  out  N  to ALU in_b
alu_out  in  N  from ALU out
alu_zero  in  1  from ALU flag_zero
alu_carry  in  1  from ALU flag_carry

Behaviour:
- Reset (rst_n low, async): state=IDLE. gnt, rsp_valid, rsp_data, rsp_zero, rsp_carry and busy are all 0. Operand/mode latches are 0. last_owner=1, so requester 0 wins the first tie. alu_enable=0.
- State machine: IDLE -> ISSUE -> WAIT -> IDLE. There are no other states; unreachable encodings go to IDLE.
- IDLE: at the rising edge where req0|req1 is sampled high:
  - Select the winner. If only one requester is active, it wins. If both are active, the winner is ~last_owner.
  - Latch the winner's mode/a/b and owner. Go to ISSUE.
  - Register gnt[owner]=1, so gnt is high for exactly the ISSUE cycle.
- ISSUE: alu_enable=1 combinationally. alu_mode/alu_a/alu_b come from the latches. The ALU captures at the end of this cycle. Next state is WAIT.
- WAIT: alu_enable=0. alu_out/alu_zero/alu_carry are valid. At the edge:
  - rsp_data<=alu_out and rsp_zero<=alu_zero.
  - rsp_carry<=alu_carry when the latched mode is ALU_ADD or ALU_SUB, else 0. This masks the ALU's stale carry.
  - rsp_valid[owner]<=1 and last_owner<=owner. Go to IDLE.
- rsp_valid is a single-cycle pulse, high in the first IDLE cycle after WAIT. rsp_data/zero/carry hold their values until the next WAIT capture.
- Latency: a request sampled at edge E0 gives gnt during E0..E1 and rsp_valid during E2..E3. Peak throughput is one operation per 3 cycles. A new request may be sampled in the same IDLE cycle that rsp_valid is high.
- Requester handshake:
  - Hold req, mode and operands stable until gnt[i] is seen.
  - Drop req in the gnt cycle, unless a further operation is intended.
  - If req is still high when the block returns to IDLE, it is a new request.
- Alternation: with req0 and req1 both held continuously, grants alternate 0,1,0,1.
- Fairness: a requester that lost arbitration wins the next arbitration if it is still requesting.
- ALU inputs: alu_mode/alu_a/alu_b always show the latched values (no glitching to requester inputs). alu_enable is high only in ISSUE.
- Invalid mode is passed through unchanged: the ALU yields 0, so rsp_zero=1 and rsp_carry=0.
- Reset mid-operation aborts the in-flight operation. No rsp_valid is generated and the ALU is left disabled.
- Width: all data is N bits. Carry semantics are the ALU's: the N+1-th bit of the sum or difference.

Test Plan:
- Single ADD: req0, a0=8'h0F, b0=8'h01, ALU_ADD -> gnt=2'b01 one cycle later; rsp_valid=2'b01 two cycles after gnt; rsp_data=8'h10, zero=0, carry=0.
- Carry/zero: req1 ALU_ADD 8'hFF+8'h01 -> rsp_valid=2'b10, rsp_data=8'h00, zero=1, carry=1. Then req1 ALU_AND 8'hF0&8'h0F -> data=0, zero=1, carry=0 (masked).
- Contention: req0 and req1 both held from reset for 4 operations -> gnt order 01,10,01,10; each rsp_valid matches the preceding gnt owner; alu_enable high exactly 1 cycle per operation.
- SUB borrow: req0 ALU_SUB 8'h03-8'h05 -> rsp_data=8'hFE, carry=1, zero=0.
- Back-to-back: req0 held through rsp_valid -> second operation sampled in the rsp_valid cycle; busy low exactly one cycle between operations.
- Reset mid-op: assert rst_n=0 during WAIT -> all outputs 0 immediately; no rsp_valid after release; next req0 is granted normally, with requester 0 winning a tie.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle between the two ALU requesters, the arbiter and the ALU.
// The arbiter uses the slave view; requesters and the ALU sit on master.
interface alu_arbiter_if #(
    parameter int N = 8
);
    logic         req0;
    logic [2:0]   mode0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         req1;
    logic [2:0]   mode1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic [1:0]   gnt;
    logic [1:0]   rsp_valid;
    logic [N-1:0] rsp_data;
    logic         rsp_zero;
    logic         rsp_carry;
    logic         busy;
    logic         alu_enable;
    logic [2:0]   alu_mode;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_out;
    logic         alu_zero;
    logic         alu_carry;

    modport master (
        output req0, mode0, a0, b0,
        output req1, mode1, a1, b1,
        input  gnt, rsp_valid, rsp_data, rsp_zero, rsp_carry, busy,
        input  alu_enable, alu_mode, alu_a, alu_b,
        output alu_out, alu_zero, alu_carry
    );

    modport slave (
        input  req0, mode0, a0, b0,
        input  req1, mode1, a1, b1,
        output gnt, rsp_valid, rsp_data, rsp_zero, rsp_carry, busy,
        output alu_enable, alu_mode, alu_a, alu_b,
        input  alu_out, alu_zero, alu_carry
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the execute
// stage (port 0) and the address/increment unit (port 1).
module alu_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic [2:0]   mode_q, mode_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] data_q, data_d;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [1:0]   vld_q, vld_d;
    logic         any_req;
    logic         pick1;

    // Arbitration, operand latching and result capture per FSM state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        gnt_d   = 2'b00;
        vld_d   = 2'b00;
        any_req = bus.req0 | bus.req1;
        // Port 1 wins alone, or on a tie when port 0 was served last.
        pick1   = bus.req1 & (~bus.req0 | ~last_q);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    owner_d = pick1;
                    mode_d  = pick1 ? bus.mode1 : bus.mode0;
                    a_d     = pick1 ? bus.a1 : bus.a0;
                    b_d     = pick1 ? bus.b1 : bus.b0;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = IDLE;
                data_d  = bus.alu_out;
                zero_d  = bus.alu_zero;
                // Only add/sub produce a fresh carry; others leave it stale.
                carry_d = bus.alu_carry &
                          ((mode_q == ALU_ADD) || (mode_q == ALU_SUB));
                vld_d   = owner_q ? 2'b10 : 2'b01;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            mode_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            gnt_q   <= 2'b00;
            vld_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = vld_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.alu_enable = (state_q == ISSUE);
    assign bus.alu_mode   = mode_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with a stand-in registered ALU.
// Expected results come from plain integer arithmetic on the operands.
module tb_alu_arbiter;
    localparam int N = 8;
    localparam logic [2:0] M_ADD = 3'd0;
    localparam logic [2:0] M_SUB = 3'd1;
    localparam logic [2:0] M_AND = 3'd2;
    localparam logic [2:0] M_OR  = 3'd3;
    localparam logic [2:0] M_XOR = 3'd4;
    localparam logic [2:0] M_BAD = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int last_win = 1;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: captures on enable, keeps carry stale for logic ops.
    logic [N:0] alu_nx;
    always_comb begin
        alu_nx = '0;
        case (bus.alu_mode)
            M_ADD: alu_nx = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            M_SUB: alu_nx = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            M_AND: alu_nx = {1'b0, bus.alu_a & bus.alu_b};
            M_OR:  alu_nx = {1'b0, bus.alu_a | bus.alu_b};
            M_XOR: alu_nx = {1'b0, bus.alu_a ^ bus.alu_b};
            default: alu_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.alu_enable) begin
            bus.alu_out  <= alu_nx[N-1:0];
            bus.alu_zero <= (alu_nx[N-1:0] == '0);
            if (bus.alu_mode == M_ADD || bus.alu_mode == M_SUB)
                bus.alu_carry <= alu_nx[N];
        end
    end

    // Expected {carry, zero, data} for a mode and operand pair.
    function automatic logic [N+1:0] expect_rsp(input logic [2:0] m,
                                                 input logic [N-1:0] a,
                                                 input logic [N-1:0] b);
        int unsigned x;
        int unsigned y;
        int unsigned r;
        logic c;
        x = a;
        y = b;
        r = 0;
        c = 1'b0;
        case (m)
            M_ADD: begin r = x + y; c = (r >= (1 << N)); end
            M_SUB: begin r = x + (1 << N) - y; c = (x < y); end
            M_AND: r = x & y;
            M_OR:  r = x | y;
            M_XOR: r = x ^ y;
            default: r = 0;
        endcase
        r = r % (1 << N);
        return {c, (r == 0), r[N-1:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.req0 = 0; bus.req1 = 0;
        bus.mode0 = '0; bus.mode1 = '0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        rst_n = 0;
        tick();
        total++;
        if ({bus.gnt, bus.rsp_valid, bus.busy, bus.alu_enable} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {bus.gnt, bus.rsp_valid, bus.busy, bus.alu_enable});
        end
        total++;
        if ({bus.rsp_data, bus.rsp_zero, bus.rsp_carry} !== '0) begin
            bad++;
            $display("FAIL reset_rsp got %h want 0",
                     {bus.rsp_data, bus.rsp_zero, bus.rsp_carry});
        end
        total++;
        if ({bus.alu_mode, bus.alu_a, bus.alu_b} !== '0) begin
            bad++;
            $display("FAIL reset_alu_in got %h want 0",
                     {bus.alu_mode, bus.alu_a, bus.alu_b});
        end
        rst_n = 1;
        last_win = 1;
        tick();
    endtask

    task automatic test_single_add;
        bus.req0 = 1; bus.mode0 = M_ADD; bus.a0 = 8'h0F; bus.b0 = 8'h01;
        tick();
        bus.req0 = 0;
        total++;
        if ({bus.gnt, bus.alu_enable, bus.busy} !== 4'b0111) begin
            bad++;
            $display("FAIL add_issue got %b want 0111",
                     {bus.gnt, bus.alu_enable, bus.busy});
        end
        total++;
        if ({bus.alu_mode, bus.alu_a, bus.alu_b} !== {M_ADD, 8'h0F, 8'h01}) begin
            bad++;
            $display("FAIL add_alu_in got %h want %h",
                     {bus.alu_mode, bus.alu_a, bus.alu_b}, {M_ADD, 8'h0F, 8'h01});
        end
        tick();
        total++;
        if ({bus.gnt, bus.alu_enable, bus.rsp_valid} !== 5'b0) begin
            bad++;
            $display("FAIL add_wait got %b want 00000",
                     {bus.gnt, bus.alu_enable, bus.rsp_valid});
        end
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
            {2'b01, 1'b0, 1'b0, 8'h10}) begin
            bad++;
            $display("FAIL add_rsp got %h want %h",
                     {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                     {2'b01, 1'b0, 1'b0, 8'h10});
        end
        last_win = 0;
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_data} !== {2'b00, 8'h10}) begin
            bad++;
            $display("FAIL add_hold got %h want %h",
                     {bus.rsp_valid, bus.rsp_data}, {2'b00, 8'h10});
        end
    endtask

    task automatic test_carry_zero;
        bus.req1 = 1; bus.mode1 = M_ADD; bus.a1 = 8'hFF; bus.b1 = 8'h01;
        tick();
        bus.req1 = 0;
        total++;
        if (bus.gnt !== 2'b10) begin
            bad++;
            $display("FAIL cz_gnt got %b want 10", bus.gnt);
        end
        tick();
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
            {2'b10, 1'b1, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL cz_add got %h want %h",
                     {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                     {2'b10, 1'b1, 1'b1, 8'h00});
        end
        bus.req1 = 1; bus.mode1 = M_AND; bus.a1 = 8'hF0; bus.b1 = 8'h0F;
        tick();
        bus.req1 = 0;
        tick();
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
            {2'b10, 1'b0, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL cz_and_mask got %h want %h",
                     {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                     {2'b10, 1'b0, 1'b1, 8'h00});
        end
        last_win = 1;
    endtask

    task automatic test_sub_borrow;
        bus.req0 = 1; bus.mode0 = M_SUB; bus.a0 = 8'h03; bus.b0 = 8'h05;
        tick();
        bus.req0 = 0;
        tick();
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
            {2'b01, 1'b1, 1'b0, 8'hFE}) begin
            bad++;
            $display("FAIL sub_borrow got %h want %h",
                     {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                     {2'b01, 1'b1, 1'b0, 8'hFE});
        end
        last_win = 0;
    endtask

    task automatic test_invalid_mode;
        bus.req1 = 1; bus.mode1 = M_BAD; bus.a1 = 8'h12; bus.b1 = 8'h34;
        tick();
        bus.req1 = 0;
        tick();
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
            {2'b10, 1'b0, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL invalid_mode got %h want %h",
                     {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                     {2'b10, 1'b0, 1'b1, 8'h00});
        end
        last_win = 1;
    endtask

    task automatic test_contention;
        int en_cnt;
        logic [1:0] want;
        logic [N+1:0] exp0;
        logic [N+1:0] exp1;
        logic [N+1:0] expv;
        en_cnt = 0;
        rst_n = 0;
        #2;
        bus.req0 = 1; bus.mode0 = M_ADD; bus.a0 = 8'h10; bus.b0 = 8'h20;
        bus.req1 = 1; bus.mode1 = M_XOR; bus.a1 = 8'hAA; bus.b1 = 8'h55;
        exp0 = expect_rsp(M_ADD, 8'h10, 8'h20);
        exp1 = expect_rsp(M_XOR, 8'hAA, 8'h55);
        rst_n = 1;
        last_win = 1;
        for (int k = 0; k < 4; k++) begin
            want = (last_win == 1) ? 2'b01 : 2'b10;
            expv = (last_win == 1) ? exp0 : exp1;
            tick();
            if (bus.alu_enable) en_cnt++;
            total++;
            if (bus.gnt !== want) begin
                bad++;
                $display("FAIL cont_gnt%0d got %b want %b", k, bus.gnt, want);
            end
            tick();
            if (bus.alu_enable) en_cnt++;
            tick();
            if (bus.alu_enable) en_cnt++;
            total++;
            if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
                {want, expv}) begin
                bad++;
                $display("FAIL cont_rsp%0d got %h want %h", k,
                         {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                         {want, expv});
            end
            last_win = (want == 2'b10) ? 1 : 0;
        end
        bus.req0 = 0;
        bus.req1 = 0;
        total++;
        if (en_cnt !== 4) begin
            bad++;
            $display("FAIL cont_enable_cycles got %0d want 4", en_cnt);
        end
    endtask

    task automatic test_back_to_back;
        bus.req0 = 1; bus.mode0 = M_ADD; bus.a0 = 8'h01; bus.b0 = 8'h02;
        tick();
        bus.mode0 = M_OR; bus.a0 = 8'h0C; bus.b0 = 8'h30;
        tick();
        tick();
        total++;
        if ({bus.rsp_valid, bus.busy, bus.rsp_data} !== {2'b01, 1'b0, 8'h03}) begin
            bad++;
            $display("FAIL b2b_first got %h want %h",
                     {bus.rsp_valid, bus.busy, bus.rsp_data}, {2'b01, 1'b0, 8'h03});
        end
        tick();
        bus.req0 = 0;
        total++;
        if ({bus.gnt, bus.busy, bus.rsp_valid} !== {2'b01, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL b2b_regrant got %b want 01100",
                     {bus.gnt, bus.busy, bus.rsp_valid});
        end
        tick();
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, 8'h3C}) begin
            bad++;
            $display("FAIL b2b_second got %h want %h",
                     {bus.rsp_valid, bus.rsp_data}, {2'b01, 8'h3C});
        end
        last_win = 0;
    endtask

    task automatic test_reset_midop;
        int stray;
        stray = 0;
        bus.req1 = 1; bus.mode1 = M_ADD; bus.a1 = 8'h40; bus.b1 = 8'h02;
        tick();
        bus.req1 = 0;
        tick();
        rst_n = 0;
        #1;
        total++;
        if ({bus.gnt, bus.rsp_valid, bus.busy, bus.alu_enable,
             bus.rsp_data, bus.rsp_zero, bus.rsp_carry, bus.alu_a} !== '0) begin
            bad++;
            $display("FAIL midop_reset got %h want 0",
                     {bus.gnt, bus.rsp_valid, bus.busy, bus.alu_enable,
                      bus.rsp_data, bus.rsp_zero, bus.rsp_carry, bus.alu_a});
        end
        #2;
        rst_n = 1;
        last_win = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL midop_stray got %0d want 0", stray);
        end
        bus.req0 = 1; bus.mode0 = M_SUB; bus.a0 = 8'h09; bus.b0 = 8'h04;
        bus.req1 = 1; bus.mode1 = M_AND; bus.a1 = 8'hFF; bus.b1 = 8'hFF;
        tick();
        bus.req0 = 0;
        bus.req1 = 0;
        total++;
        if (bus.gnt !== 2'b01) begin
            bad++;
            $display("FAIL midop_tie got %b want 01", bus.gnt);
        end
        tick();
        tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
            {2'b01, 1'b0, 1'b0, 8'h05}) begin
            bad++;
            $display("FAIL midop_after got %h want %h",
                     {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                     {2'b01, 1'b0, 1'b0, 8'h05});
        end
        last_win = 0;
    endtask

    task automatic test_random;
        int r;
        int w;
        logic [2:0] m;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0] want;
        logic [N+1:0] expv;
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(1, 3);
            bus.req0 = r[0];
            bus.req1 = r[1];
            bus.mode0 = 3'($urandom_range(0, 7));
            bus.mode1 = 3'($urandom_range(0, 7));
            bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
            bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
            if (r == 3) w = 1 - last_win;
            else w = (r == 2) ? 1 : 0;
            m = (w == 1) ? bus.mode1 : bus.mode0;
            a = (w == 1) ? bus.a1 : bus.a0;
            b = (w == 1) ? bus.b1 : bus.b0;
            want = (w == 1) ? 2'b10 : 2'b01;
            expv = expect_rsp(m, a, b);
            tick();
            bus.req0 = 0;
            bus.req1 = 0;
            total++;
            if ({bus.gnt, bus.alu_enable, bus.alu_mode, bus.alu_a, bus.alu_b} !==
                {want, 1'b1, m, a, b}) begin
                bad++;
                $display("FAIL rnd_issue%0d got %h want %h", k,
                         {bus.gnt, bus.alu_enable, bus.alu_mode, bus.alu_a, bus.alu_b},
                         {want, 1'b1, m, a, b});
            end
            tick();
            tick();
            total++;
            if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data} !==
                {want, expv}) begin
                bad++;
                $display("FAIL rnd_rsp%0d got %h want %h", k,
                         {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                         {want, expv});
            end
            last_win = w;
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry_zero();
        test_sub_borrow();
        test_invalid_mode();
        test_back_to_back();
        test_contention();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
